pcpu_int_ctrl: RTL

Interrupt responder for the PCPU pipeline: captures the two external interrupt request lines `interrupt_one` (low priority) and `interrupt_two` (high priority) driven by the system or bench. It synchronises and latches them, arbitrates priority, and hands the pipeline a vector through a request/acknowledge handshake. It keeps a two-deep EPC stack so a level-two interrupt can preempt a level-one handler, and it unwinds the stack on `eret`.

---
 rtl/pcpu_int_pkg.sv | 31 +++
 rtl/int_edge_sync.sv | 29 ++
 rtl/pcpu_int_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pcpu_int_pkg.sv
// PCPU interrupt responder shared types and constants.
// PCPU_INT_NEST_EN enables level-two preemption of a level-one handler.
package pcpu_int_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ1  = 3'd1,
        ST_REQ2  = 3'd2,
        ST_SVC1  = 3'd3,
        ST_SVC2  = 3'd4
`ifdef PCPU_INT_NEST_EN
        ,
        ST_REQ2N = 3'd5,
        ST_SVC2N = 3'd6
`endif
    } int_state_t;

    localparam logic [1:0] LVL_NONE = 2'd0;
    localparam logic [1:0] LVL_ONE  = 2'd1;
    localparam logic [1:0] LVL_TWO  = 2'd2;

    localparam logic [31:0] VEC_ONE_DEF = 32'h0000_0040;
    localparam logic [31:0] VEC_TWO_DEF = 32'h0000_0080;

`ifdef PCPU_INT_NEST_EN
    localparam logic [1:0] EPC_DEPTH = 2'd2;
`else
    localparam logic [1:0] EPC_DEPTH = 2'd1;
`endif

endpackage

// File: rtl/int_edge_sync.sv
// Two-flop synchroniser for an async request line
// followed by a rising-edge detector on the synchronised level.
module int_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // sync chain plus one delayed copy for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/pcpu_int_ctrl.sv
// PCPU interrupt responder: sync, priority, req/ack handshake, EPC stack.
// PCPU_INT_NEST_EN adds REQ2N/SVC2N and a second EPC stack entry.
module pcpu_int_ctrl
    import pcpu_int_pkg::*;
#(
    parameter logic [31:0] VEC_ONE = VEC_ONE_DEF,
    parameter logic [31:0] VEC_TWO = VEC_TWO_DEF
) (
    input  logic        clk_cpu,
    input  logic        rst_n,
    input  logic        interrupt_one,
    input  logic        interrupt_two,
    input  logic        int_ack,
    input  logic [31:0] epc_in,
    input  logic        eret,
    output logic        int_req,
    output logic [31:0] int_vector,
    output logic [31:0] epc_out,
    output logic [1:0]  int_level
);

    logic       rise_one;
    logic       rise_two;
    logic       pend_one;
    logic       pend_two;
    logic       clr_one;
    logic       clr_two;
    logic       push;
    logic       pop;
    logic       req_d;
    logic [31:0] vec_d;
    logic [1:0] lvl_d;
    logic [1:0] depth;
    logic [31:0] stk0;
`ifdef PCPU_INT_NEST_EN
    logic [31:0] stk1;
`endif
    int_state_t state;
    int_state_t nxt;

    int_edge_sync u_sync_one (
        .clk      (clk_cpu),
        .rst_n    (rst_n),
        .async_in (interrupt_one),
        .rise     (rise_one)
    );

    int_edge_sync u_sync_two (
        .clk      (clk_cpu),
        .rst_n    (rst_n),
        .async_in (interrupt_two),
        .rise     (rise_two)
    );

    // next state plus stack and pending side effects
    always_comb begin
        nxt     = state;
        push    = 1'b0;
        pop     = 1'b0;
        clr_one = 1'b0;
        clr_two = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend_two)      nxt = ST_REQ2;
                else if (pend_one) nxt = ST_REQ1;
            end
            ST_REQ1: begin
                if (int_ack) begin
                    nxt     = ST_SVC1;
                    push    = 1'b1;
                    clr_one = 1'b1;
                end else if (pend_two) begin
                    nxt = ST_REQ2;
                end
            end
            ST_REQ2: begin
                if (int_ack) begin
                    nxt     = ST_SVC2;
                    push    = 1'b1;
                    clr_two = 1'b1;
                end
            end
            ST_SVC1: begin
`ifdef PCPU_INT_NEST_EN
                if (pend_two && eret) begin
                    nxt = ST_REQ2;
                    pop = 1'b1;
                end else if (pend_two) begin
                    nxt = ST_REQ2N;
                end else if (eret) begin
                    nxt = ST_IDLE;
                    pop = 1'b1;
                end
`else
                if (eret) begin
                    nxt = pend_two ? ST_REQ2 : ST_IDLE;
                    pop = 1'b1;
                end
`endif
            end
            ST_SVC2: begin
                if (eret) begin
                    nxt = ST_IDLE;
                    pop = 1'b1;
                end
            end
`ifdef PCPU_INT_NEST_EN
            ST_REQ2N: begin
                if (int_ack) begin
                    nxt     = ST_SVC2N;
                    push    = 1'b1;
                    clr_two = 1'b1;
                end else if (eret) begin
                    nxt = ST_REQ2;
                    pop = 1'b1;
                end
            end
            ST_SVC2N: begin
                if (eret) begin
                    nxt = ST_SVC1;
                    pop = 1'b1;
                end
            end
`endif
            default: nxt = ST_IDLE;
        endcase
    end

    // Moore output decode of the upcoming state
    always_comb begin
        req_d = 1'b0;
        vec_d = '0;
        lvl_d = LVL_NONE;
        unique case (1'b1)
            (nxt == ST_REQ1): begin
                req_d = 1'b1;
                vec_d = VEC_ONE;
            end
            (nxt == ST_REQ2): begin
                req_d = 1'b1;
                vec_d = VEC_TWO;
            end
            (nxt == ST_SVC1): lvl_d = LVL_ONE;
            (nxt == ST_SVC2): lvl_d = LVL_TWO;
`ifdef PCPU_INT_NEST_EN
            (nxt == ST_REQ2N): begin
                req_d = 1'b1;
                vec_d = VEC_TWO;
                lvl_d = LVL_ONE;
            end
            (nxt == ST_SVC2N): lvl_d = LVL_TWO;
`endif
            default: ;
        endcase
    end

    // state register with registered outputs
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            int_req    <= 1'b0;
            int_vector <= '0;
            int_level  <= LVL_NONE;
        end else begin
            state      <= nxt;
            int_req    <= req_d;
            int_vector <= vec_d;
            int_level  <= lvl_d;
        end
    end

    // pending bits: a new edge wins over a same-cycle clear
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            pend_one <= 1'b0;
            pend_two <= 1'b0;
        end else begin
            pend_one <= rise_one | (pend_one & ~clr_one);
            pend_two <= rise_two | (pend_two & ~clr_two);
        end
    end

    // EPC stack storage and depth
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            depth <= 2'd0;
            stk0  <= '0;
`ifdef PCPU_INT_NEST_EN
            stk1  <= '0;
`endif
        end else if (push) begin
`ifdef PCPU_INT_NEST_EN
            if (depth == 2'd0) stk0 <= epc_in;
            else               stk1 <= epc_in;
`else
            stk0 <= epc_in;
`endif
            depth <= depth + 2'd1;
        end else if (pop) begin
            depth <= depth - 2'd1;
        end
    end

`ifdef PCPU_INT_NEST_EN
    assign epc_out = (depth == 2'd2) ? stk1 :
                     (depth == 2'd1) ? stk0 : '0;
`else
    assign epc_out = (depth != 2'd0) ? stk0 : '0;
`endif

    a_no_overflow: assert property (@(posedge clk_cpu) disable iff (!rst_n)
        !(push && depth == EPC_DEPTH));
    a_no_underflow: assert property (@(posedge clk_cpu) disable iff (!rst_n)
        !(pop && depth == 2'd0));

endmodule
